// File: rtl/lsu_arbiter.sv
// lsu_arbiter
//   Two-port arbiter and sequencer in front of the shared LSU. Port 0 is the
//   pipeline MEM stage, port 1 is the debug/DMA loader. One request is taken
//   at a time through valid/ready. The granted request is latched and drives
//   the LSU for one cycle. The load data is registered and returned to the
//   granted port with a one-cycle rsp_valid pulse.
//
// Parameters
//   FIXED_PRIO : 0 = round-robin between ports, 1 = port 0 wins every conflict
//   ADDR_W     : address width
//   DATA_W     : data width
//
// Ports
//   i_clk, i_reset                 clock, synchronous active-high reset
//   i_pN_valid / o_pN_ready        request handshake (ready is combinational)
//   i_pN_wren, i_pN_addr,
//   i_pN_wdata, i_pN_slt_sl        request fields (store flag, addr, data, type)
//   o_pN_rsp_valid, o_pN_rdata     response pulse and held load data
//   o_lsu_wren, o_lsu_addr,
//   o_st_data, o_slt_sl            LSU request bus (from latched fields)
//   i_ld_data                      LSU combinational load data
//   o_busy                         high whenever the FSM is not idle
//
// Optional feature, macro LSU_ARB_ERR_EN
//   Adds o_p0_err / o_p1_err. Addresses outside the legal map suppress the
//   LSU write, return rdata 0 and flag err together with rsp_valid.
//
// state  | meaning
// IDLE   | waiting for a request; grant is combinational in this state
// ACCESS | latched request drives the LSU; load data captured at cycle end
// RESP   | rsp_valid pulse to the granted port; no request accepted

module lsu_arbiter #(
    parameter int FIXED_PRIO = 0,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,

    input  logic              i_p0_valid,
    output logic              o_p0_ready,
    input  logic              i_p0_wren,
    input  logic [ADDR_W-1:0] i_p0_addr,
    input  logic [DATA_W-1:0] i_p0_wdata,
    input  logic [2:0]        i_p0_slt_sl,
    output logic              o_p0_rsp_valid,
    output logic [DATA_W-1:0] o_p0_rdata,

    input  logic              i_p1_valid,
    output logic              o_p1_ready,
    input  logic              i_p1_wren,
    input  logic [ADDR_W-1:0] i_p1_addr,
    input  logic [DATA_W-1:0] i_p1_wdata,
    input  logic [2:0]        i_p1_slt_sl,
    output logic              o_p1_rsp_valid,
    output logic [DATA_W-1:0] o_p1_rdata,

`ifdef LSU_ARB_ERR_EN
    output logic              o_p0_err,
    output logic              o_p1_err,
`endif

    output logic              o_lsu_wren,
    output logic [ADDR_W-1:0] o_lsu_addr,
    output logic [DATA_W-1:0] o_st_data,
    output logic [2:0]        o_slt_sl,
    input  logic [DATA_W-1:0] i_ld_data,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic              req_wren;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [2:0]        req_sl;
    logic              req_id;
    logic              last_grant;
    logic [DATA_W-1:0] p0_rdata;
    logic [DATA_W-1:0] p1_rdata;

    logic              grant_vld;
    logic              grant_id;
    logic              sel_wren;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [2:0]        sel_sl;
    logic              access_wren;
    logic [DATA_W-1:0] cap_data;

    // Grant is only offered in IDLE and never while reset is held, so a
    // request can't be lost to a reset in the accept cycle.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        if (state == IDLE && !i_reset) begin
            if (i_p0_valid && i_p1_valid) begin
                grant_vld = 1'b1;
                grant_id  = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
            end else if (i_p0_valid) begin
                grant_vld = 1'b1;
                grant_id  = 1'b0;
            end else if (i_p1_valid) begin
                grant_vld = 1'b1;
                grant_id  = 1'b1;
            end
        end
    end

    always_comb begin
        sel_wren  = grant_id ? i_p1_wren   : i_p0_wren;
        sel_addr  = grant_id ? i_p1_addr   : i_p0_addr;
        sel_wdata = grant_id ? i_p1_wdata  : i_p0_wdata;
        sel_sl    = grant_id ? i_p1_slt_sl : i_p0_slt_sl;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_vld) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef LSU_ARB_ERR_EN
    logic req_err;

    function automatic logic addr_illegal(input logic [ADDR_W-1:0] a);
        logic legal;
        legal = (a <= ADDR_W'(32'h0000_07FF)) ||
                (a >= ADDR_W'(32'h1000_0000) && a <= ADDR_W'(32'h1000_4FFF)) ||
                (a >= ADDR_W'(32'h1001_0000) && a <= ADDR_W'(32'h1001_0FFF));
        return !legal;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_reset)        req_err <= 1'b0;
        else if (grant_vld) req_err <= addr_illegal(sel_addr);
    end

    assign access_wren = req_wren && !req_err;
    assign cap_data    = req_err ? '0 : i_ld_data;
    assign o_p0_err    = o_p0_rsp_valid && req_err;
    assign o_p1_err    = o_p1_rsp_valid && req_err;
`else
    assign access_wren = req_wren;
    assign cap_data    = i_ld_data;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= IDLE;
            req_wren   <= 1'b0;
            req_addr   <= '0;
            req_wdata  <= '0;
            req_sl     <= 3'b000;
            req_id     <= 1'b0;
            last_grant <= 1'b1;
            p0_rdata   <= '0;
            p1_rdata   <= '0;
        end else begin
            state <= state_nxt;
            if (grant_vld) begin
                req_wren   <= sel_wren;
                req_addr   <= sel_addr;
                req_wdata  <= sel_wdata;
                req_sl     <= sel_sl;
                req_id     <= grant_id;
                last_grant <= grant_id;
            end
            if (state == ACCESS) begin
                if (req_id) p1_rdata <= cap_data;
                else        p0_rdata <= cap_data;
            end
        end
    end

    assign o_p0_ready     = grant_vld && !grant_id;
    assign o_p1_ready     = grant_vld &&  grant_id;
    // Gated by reset so a response pending at reset is dropped in that cycle.
    assign o_p0_rsp_valid = (state == RESP) && !req_id && !i_reset;
    assign o_p1_rsp_valid = (state == RESP) &&  req_id && !i_reset;
    assign o_p0_rdata     = p0_rdata;
    assign o_p1_rdata     = p1_rdata;

    assign o_lsu_wren     = (state == ACCESS) && access_wren && !i_reset;
    assign o_lsu_addr     = req_addr;
    assign o_st_data      = req_wdata;
    assign o_slt_sl       = req_sl;
    assign o_busy         = (state != IDLE);

endmodule

// File: tb/tb_lsu_arbiter.sv
module tb_lsu_arbiter;

    logic        clk;
    logic        rst;

    logic        p0_wren, p1_wren;
    logic [31:0] p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;
    logic [2:0]  p0_sl, p1_sl;

    logic        a_p0_valid, a_p1_valid, a_p0_ready, a_p1_ready;
    logic        a_p0_rsp, a_p1_rsp;
    logic [31:0] a_p0_rdata, a_p1_rdata;
    logic        a_lsu_wren, a_busy;
    logic [31:0] a_lsu_addr, a_st_data, a_ld_data;
    logic [2:0]  a_slt_sl;

    logic        b_p0_valid, b_p1_valid, b_p0_ready, b_p1_ready;
    logic        b_p0_rsp, b_p1_rsp;
    logic [31:0] b_p0_rdata, b_p1_rdata;
    logic        b_lsu_wren, b_busy;
    logic [31:0] b_lsu_addr, b_st_data, b_ld_data;
    logic [2:0]  b_slt_sl;

`ifdef LSU_ARB_ERR_EN
    logic a_p0_err, a_p1_err, b_p0_err, b_p1_err;
`endif

    int total = 0;
    int bad   = 0;

    lsu_arbiter #(.FIXED_PRIO(0), .ADDR_W(32), .DATA_W(32)) dut_a (
        .i_clk(clk), .i_reset(rst),
        .i_p0_valid(a_p0_valid), .o_p0_ready(a_p0_ready), .i_p0_wren(p0_wren),
        .i_p0_addr(p0_addr), .i_p0_wdata(p0_wdata), .i_p0_slt_sl(p0_sl),
        .o_p0_rsp_valid(a_p0_rsp), .o_p0_rdata(a_p0_rdata),
        .i_p1_valid(a_p1_valid), .o_p1_ready(a_p1_ready), .i_p1_wren(p1_wren),
        .i_p1_addr(p1_addr), .i_p1_wdata(p1_wdata), .i_p1_slt_sl(p1_sl),
        .o_p1_rsp_valid(a_p1_rsp), .o_p1_rdata(a_p1_rdata),
`ifdef LSU_ARB_ERR_EN
        .o_p0_err(a_p0_err), .o_p1_err(a_p1_err),
`endif
        .o_lsu_wren(a_lsu_wren), .o_lsu_addr(a_lsu_addr), .o_st_data(a_st_data),
        .o_slt_sl(a_slt_sl), .i_ld_data(a_ld_data), .o_busy(a_busy)
    );

    lsu_arbiter #(.FIXED_PRIO(1), .ADDR_W(32), .DATA_W(32)) dut_b (
        .i_clk(clk), .i_reset(rst),
        .i_p0_valid(b_p0_valid), .o_p0_ready(b_p0_ready), .i_p0_wren(p0_wren),
        .i_p0_addr(p0_addr), .i_p0_wdata(p0_wdata), .i_p0_slt_sl(p0_sl),
        .o_p0_rsp_valid(b_p0_rsp), .o_p0_rdata(b_p0_rdata),
        .i_p1_valid(b_p1_valid), .o_p1_ready(b_p1_ready), .i_p1_wren(p1_wren),
        .i_p1_addr(p1_addr), .i_p1_wdata(p1_wdata), .i_p1_slt_sl(p1_sl),
        .o_p1_rsp_valid(b_p1_rsp), .o_p1_rdata(b_p1_rdata),
`ifdef LSU_ARB_ERR_EN
        .o_p0_err(b_p0_err), .o_p1_err(b_p1_err),
`endif
        .o_lsu_wren(b_lsu_wren), .o_lsu_addr(b_lsu_addr), .o_st_data(b_st_data),
        .o_slt_sl(b_slt_sl), .i_ld_data(b_ld_data), .o_busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Small word memory behind instance A, preloaded on every reset.
    logic [31:0] mem [0:15];
    assign a_ld_data = mem[a_lsu_addr[5:2]];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'hA000_0000 + i;
        end else if (a_lsu_wren) begin
            mem[a_lsu_addr[5:2]] <= a_st_data;
        end
    end

    assign b_ld_data = b_lsu_addr ^ 32'h5A5A_0000;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({a_p0_ready, a_p1_ready, a_p0_rsp, a_p1_rsp, a_busy, a_lsu_wren} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=000000",
                     {a_p0_ready, a_p1_ready, a_p0_rsp, a_p1_rsp, a_busy, a_lsu_wren});
        end
        total++;
        if (a_lsu_addr !== 32'h0 || a_st_data !== 32'h0 || a_slt_sl !== 3'b000) begin
            bad++;
            $display("FAIL reset_bus addr=%h st=%h sl=%b want 0", a_lsu_addr, a_st_data, a_slt_sl);
        end
        total++;
        if (a_p0_rdata !== 32'h0 || a_p1_rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_rdata p0=%h p1=%h want 0", a_p0_rdata, a_p1_rdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_store();
        @(negedge clk);
        p0_wren = 1'b1; p0_addr = 32'h0000_0010; p0_wdata = 32'hDEAD_BEEF; p0_sl = 3'b010;
        a_p0_valid = 1'b1;
        #1;
        total++;
        if ({a_p0_ready, a_p1_ready, a_lsu_wren} !== 3'b100) begin
            bad++;
            $display("FAIL store_accept got=%b want=100", {a_p0_ready, a_p1_ready, a_lsu_wren});
        end
        @(negedge clk);
        a_p0_valid = 1'b0;
        #1;
        total++;
        if (a_lsu_wren !== 1'b1 || a_lsu_addr !== 32'h10 || a_st_data !== 32'hDEAD_BEEF ||
            a_slt_sl !== 3'b010 || a_busy !== 1'b1 || a_p0_ready !== 1'b0 || a_p0_rsp !== 1'b0) begin
            bad++;
            $display("FAIL store_access wren=%b addr=%h st=%h sl=%b busy=%b rdy=%b rsp=%b want 1/10/deadbeef/010/1/0/0",
                     a_lsu_wren, a_lsu_addr, a_st_data, a_slt_sl, a_busy, a_p0_ready, a_p0_rsp);
        end
        @(negedge clk);
        #1;
        total++;
        if ({a_lsu_wren, a_p0_rsp, a_p1_rsp, a_busy, a_p0_ready} !== 5'b01010) begin
            bad++;
            $display("FAIL store_resp got=%b want=01010", {a_lsu_wren, a_p0_rsp, a_p1_rsp, a_busy, a_p0_ready});
        end
`ifdef LSU_ARB_ERR_EN
        total++;
        if (a_p0_err !== 1'b0) begin
            bad++;
            $display("FAIL store_err got=%b want=0", a_p0_err);
        end
`endif
        @(negedge clk);
        #1;
        total++;
        if ({a_p0_rsp, a_busy, a_lsu_wren} !== 3'b000) begin
            bad++;
            $display("FAIL store_idle got=%b want=000", {a_p0_rsp, a_busy, a_lsu_wren});
        end
    endtask

    task automatic test_store_load();
        @(negedge clk);
        p0_wren = 1'b0; p0_addr = 32'h0000_0010; p0_wdata = 32'h0; p0_sl = 3'b101;
        a_p0_valid = 1'b1;
        #1;
        total++;
        if (a_p0_ready !== 1'b1) begin
            bad++;
            $display("FAIL load_accept got=%b want=1", a_p0_ready);
        end
        @(negedge clk);
        a_p0_valid = 1'b0;
        #1;
        total++;
        if (a_lsu_wren !== 1'b0 || a_lsu_addr !== 32'h10 || a_slt_sl !== 3'b101) begin
            bad++;
            $display("FAIL load_access wren=%b addr=%h sl=%b want 0/10/101", a_lsu_wren, a_lsu_addr, a_slt_sl);
        end
        @(negedge clk);
        #1;
        total++;
        if (a_p0_rsp !== 1'b1 || a_p1_rsp !== 1'b0 || a_p0_rdata !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL load_resp rsp0=%b rsp1=%b rdata=%h want 1/0/deadbeef", a_p0_rsp, a_p1_rsp, a_p0_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int n;
        do_reset();
        p0_wren = 1'b0; p0_addr = 32'h4; p0_sl = 3'b101;
        p1_wren = 1'b0; p1_addr = 32'h8; p1_sl = 3'b101;
        @(negedge clk);
        a_p0_valid = 1'b1; a_p1_valid = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!(a_p0_ready || a_p1_ready) && n < 6) begin
                @(negedge clk); #1; n++;
            end
            total++;
            if ({a_p1_ready, a_p0_ready} !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                bad++;
                $display("FAIL rr_grant%0d got=%b want=%b", k, {a_p1_ready, a_p0_ready},
                         (k % 2 == 0) ? 2'b01 : 2'b10);
            end
            @(negedge clk); #1;
            total++;
            if (a_lsu_addr !== ((k % 2 == 0) ? 32'h4 : 32'h8) || a_p0_ready !== 1'b0 || a_p1_ready !== 1'b0) begin
                bad++;
                $display("FAIL rr_access%0d addr=%h rdy=%b%b want %h/00", k, a_lsu_addr, a_p1_ready, a_p0_ready,
                         (k % 2 == 0) ? 32'h4 : 32'h8);
            end
            @(negedge clk); #1;
            total++;
            if ({a_p1_rsp, a_p0_rsp} !== ((k % 2 == 0) ? 2'b01 : 2'b10) ||
                ((k % 2 == 0) ? a_p0_rdata : a_p1_rdata) !== ((k % 2 == 0) ? 32'hA000_0001 : 32'hA000_0002)) begin
                bad++;
                $display("FAIL rr_resp%0d rsp=%b rd0=%h rd1=%h want %b/a0000001|a0000002", k,
                         {a_p1_rsp, a_p0_rsp}, a_p0_rdata, a_p1_rdata, (k % 2 == 0) ? 2'b01 : 2'b10);
            end
            if (k < 3) begin
                @(negedge clk); #1;
            end
        end
        @(negedge clk);
        a_p0_valid = 1'b0; a_p1_valid = 1'b0;
        #1;
        total++;
        if (a_busy !== 1'b0 || a_p0_rdata !== 32'hA000_0001 || a_p1_rdata !== 32'hA000_0002) begin
            bad++;
            $display("FAIL rr_hold busy=%b rd0=%h rd1=%h want 0/a0000001/a0000002", a_busy, a_p0_rdata, a_p1_rdata);
        end
    endtask

    task automatic test_fixed_prio();
        int n;
        do_reset();
        p0_wren = 1'b0; p0_addr = 32'h4; p0_sl = 3'b101;
        p1_wren = 1'b0; p1_addr = 32'h8; p1_sl = 3'b101;
        @(negedge clk);
        b_p0_valid = 1'b1; b_p1_valid = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!(b_p0_ready || b_p1_ready) && n < 6) begin
                @(negedge clk); #1; n++;
            end
            total++;
            if ({b_p1_ready, b_p0_ready} !== ((k < 3) ? 2'b01 : 2'b10)) begin
                bad++;
                $display("FAIL fp_grant%0d got=%b want=%b", k, {b_p1_ready, b_p0_ready}, (k < 3) ? 2'b01 : 2'b10);
            end
            @(negedge clk); #1;
            @(negedge clk);
            if (k == 2) b_p0_valid = 1'b0;
            #1;
            total++;
            if ({b_p1_rsp, b_p0_rsp} !== ((k < 3) ? 2'b01 : 2'b10) ||
                ((k < 3) ? b_p0_rdata : b_p1_rdata) !== ((k < 3) ? 32'h5A5A_0004 : 32'h5A5A_0008)) begin
                bad++;
                $display("FAIL fp_resp%0d rsp=%b rd0=%h rd1=%h want %b/5a5a0004|5a5a0008", k,
                         {b_p1_rsp, b_p0_rsp}, b_p0_rdata, b_p1_rdata, (k < 3) ? 2'b01 : 2'b10);
            end
            if (k < 3) begin
                @(negedge clk); #1;
            end
        end
        @(negedge clk);
        b_p1_valid = 1'b0;
    endtask

    task automatic test_reset_mid_store();
        @(negedge clk);
        p1_wren = 1'b1; p1_addr = 32'h1000_0000; p1_wdata = 32'h0000_0055; p1_sl = 3'b000;
        a_p1_valid = 1'b1;
        #1;
        total++;
        if (a_p1_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_accept got=%b want=1", a_p1_ready);
        end
        @(negedge clk);
        a_p1_valid = 1'b0;
        rst = 1'b1;
        #1;
        total++;
        if (a_lsu_wren !== 1'b0) begin
            bad++;
            $display("FAIL rst_wren got=%b want=0", a_lsu_wren);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if ({a_busy, a_p0_rsp, a_p1_rsp, a_lsu_wren} !== 4'b0 || a_lsu_addr !== 32'h0 || a_p1_rdata !== 32'h0) begin
            bad++;
            $display("FAIL rst_after busy/rsp/wren=%b addr=%h rd1=%h want 0000/0/0",
                     {a_busy, a_p0_rsp, a_p1_rsp, a_lsu_wren}, a_lsu_addr, a_p1_rdata);
        end
        @(negedge clk);
        #1;
        total++;
        if ({a_busy, a_p0_rsp, a_p1_rsp} !== 3'b000) begin
            bad++;
            $display("FAIL rst_norsp got=%b want=000", {a_busy, a_p0_rsp, a_p1_rsp});
        end
    endtask

`ifdef LSU_ARB_ERR_EN
    task automatic test_illegal_addr();
        @(negedge clk);
        p1_wren = 1'b1; p1_addr = 32'h2000_0000; p1_wdata = 32'h1234_5678; p1_sl = 3'b010;
        a_p1_valid = 1'b1;
        #1;
        total++;
        if (a_p1_ready !== 1'b1) begin
            bad++;
            $display("FAIL err_accept got=%b want=1", a_p1_ready);
        end
        @(negedge clk);
        a_p1_valid = 1'b0;
        #1;
        total++;
        if (a_lsu_wren !== 1'b0) begin
            bad++;
            $display("FAIL err_wren got=%b want=0", a_lsu_wren);
        end
        @(negedge clk);
        #1;
        total++;
        if (a_p1_rsp !== 1'b1 || a_p1_err !== 1'b1 || a_p1_rdata !== 32'h0 || a_p0_err !== 1'b0) begin
            bad++;
            $display("FAIL err_resp rsp=%b err1=%b err0=%b rd1=%h want 1/1/0/0", a_p1_rsp, a_p1_err, a_p0_err, a_p1_rdata);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        rst = 1'b1;
        a_p0_valid = 1'b0; a_p1_valid = 1'b0; b_p0_valid = 1'b0; b_p1_valid = 1'b0;
        p0_wren = 1'b0; p0_addr = 32'h0; p0_wdata = 32'h0; p0_sl = 3'b000;
        p1_wren = 1'b0; p1_addr = 32'h0; p1_wdata = 32'h0; p1_sl = 3'b000;
        test_reset();
        test_single_store();
        test_store_load();
        test_round_robin();
        test_fixed_prio();
        test_reset_mid_store();
`ifdef LSU_ARB_ERR_EN
        test_illegal_addr();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_arbiter.md
Name: lsu_arbiter

Overview:
- Two-port arbiter and sequencer in front of the shared `lsu`.
- Port 0 is the pipeline MEM stage. Port 1 is the debug/DMA loader.
- The block accepts one request at a time through a valid/ready handshake, selects between the ports in round-robin or fixed priority, and drives the LSU from registered request fields.
- It returns a registered load-data response to the requester that was granted.

Parameters:
- FIXED_PRIO, 0: 0 = round-robin between ports; 1 = port 0 wins every conflict.
- ADDR_W, 32: address width of the request and LSU address buses.
- DATA_W, 32: data width of store data, load data and response data.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_p0_valid  in  1  port 0 request valid
- o_p0_ready  out  1  port 0 request accepted this cycle
- i_p0_wren  in  1  port 0 store (1) / load (0)
- i_p0_addr  in  ADDR_W  port 0 address
- i_p0_wdata  in  DATA_W  port 0 store data
- i_p0_slt_sl  in  3  port 0 access type (SB=000 SH=001 SW=010 LB=011 LH=100 LW=101 LBU=110 LHU=111)
- o_p0_rsp_valid  out  1  port 0 response pulse
- o_p0_rdata  out  DATA_W  port 0 response data
- i_p1_valid, o_p1_ready, i_p1_wren, i_p1_addr, i_p1_wdata, i_p1_slt_sl, o_p1_rsp_valid, o_p1_rdata: same as port 0, for port 1
- o_lsu_wren  out  1  LSU write enable
- o_lsu_addr  out  ADDR_W  LSU address
- o_st_data  out  DATA_W  LSU store data
- o_slt_sl  out  3  LSU access type
- i_ld_data  in  DATA_W  LSU combinational load data
- o_busy  out  1  high whenever state != IDLE

Behaviour:
- Clocking and reset:
  - One clock, i_clk. i_reset is synchronous and active-high.
  - While i_reset is high, o_lsu_wren is also forced 0 combinationally.
- Reset values:
  - state=IDLE; all ready and rsp_valid outputs 0; o_pN_rdata 0.
  - Latched req fields 0, so o_lsu_addr=0, o_st_data=0, o_slt_sl=000, o_lsu_wren=0.
  - last_grant=1, so port 0 wins the first conflict.
- FSM state IDLE:
  - If any i_pN_valid is high, grant one port: assert o_pN_ready combinationally in that cycle.
  - Latch wren/addr/wdata/slt_sl and the granted id; go to ACCESS.
  - No valid: stay in IDLE.
- FSM state ACCESS:
  - Drive the LSU bus from the latched fields. o_lsu_wren = latched wren, for exactly this one cycle.
  - Capture i_ld_data into the granted port's rdata register at the end of the cycle; stores capture it too, so rdata is don't-care for a store.
  - Go to RESP.
- FSM state RESP:
  - o_pN_rsp_valid=1 for the granted port only, for exactly 1 cycle; go to IDLE.
  - No request is accepted in RESP.
- Outside ACCESS, o_lsu_wren=0 and the LSU bus holds the last latched fields.
- Latency and throughput:
  - Accept at cycle T; LSU access at T+1; rsp_valid at T+2.
  - Next accept no earlier than T+3, i.e. one transaction per 3 cycles.
- Arbitration:
  - Only one port valid: that port is granted.
  - Both valid, FIXED_PRIO=0: grant the port != last_grant.
  - Both valid, FIXED_PRIO=1: grant port 0.
  - last_grant updates on every accept.
- Requester rules:
  - Hold valid and all fields stable until ready.
  - Dropping valid before ready is legal; no transaction results.
  - The losing port keeps its valid and is served at the next IDLE.
- o_pN_rdata holds its value until that port's next response capture.
- Reset in ACCESS or RESP:
  - No LSU write in the reset cycle; the pending response is discarded.
  - After reset, state=IDLE with no rsp_valid.

Optional Feature:
- Macro LSU_ARB_ERR_EN, enabled:
  - Adds output o_p0_err and output o_p1_err.
  - At accept, the address is decoded. Legal ranges: 0x0000_0000–0x0000_07FF (mem), 0x1000_0000–0x1000_4FFF (output periph), 0x1001_0000–0x1001_0FFF (switch).
  - Illegal address: ACCESS keeps o_lsu_wren=0, rdata is captured as 0, and o_pN_err=1 is asserted with the rsp_valid pulse.
- Macro not defined: no err ports; every address is passed to the LSU unchanged.

Test Plan:
- Single store:
  - Stimulus: reset, then p0 SW addr 0x0000_0010 data 0xDEADBEEF.
  - Response: o_p0_ready at T, o_lsu_wren=1 only at T+1, o_p0_rsp_valid at T+2.
- Store then load:
  - Stimulus: p0 LW addr 0x0000_0010 after the store above.
  - Response: o_p0_rdata=0xDEADBEEF with rsp_valid.
- Simultaneous requests, FIXED_PRIO=0:
  - Stimulus: p0 and p1 valid together for 4 transactions.
  - Response: grants p0,p1,p0,p1; each response goes only to its own port.
- Simultaneous requests, FIXED_PRIO=1:
  - Stimulus: p0 and p1 valid together.
  - Response: p0 granted every time while p0 stays valid; p1 granted once p0 drops.
- Reset mid-store:
  - Stimulus: i_reset high in ACCESS of an SB to 0x1000_0000.
  - Response: o_lsu_wren=0 that cycle, no rsp_valid, o_busy=0 the cycle after.
- Illegal address with LSU_ARB_ERR_EN defined:
  - Stimulus: p1 SW to 0x2000_0000.
  - Response: no LSU write, o_p1_rsp_valid=1 with o_p1_err=1 and o_p1_rdata=0.
